// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the branch predictor and resolver.
package rv32i_types;

  // Resolution feedback sent from EX back to the bimodal predictor.
  typedef struct packed {
    logic mp_valid;
    logic mispredicted;
  } brp_ex_t;

endpackage

// File: rtl/brq_fifo.sv
// In-order 1-bit FIFO of predicted directions with a single-cycle flush.
module brq_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = PTR_W + 1;

  logic [DEPTH-1:0]    r_mem;
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_BITS-1:0] r_count;

  // Storage write; flushed pushes are wrong-path and never land.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/br_resolver.sv
// Matches in-flight branch predictions against EX outcomes, drives predictor
// feedback and fetch redirects, and keeps resolution statistics.
module br_resolver
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_pc_plus4,
  output brp_ex_t          brp_ex,
  output logic             update,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count,
  output logic             underflow_err
);

  localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1;

  typedef enum logic {
    S_RUN,
    S_RECOVER
  } state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [CNT_BITS-1:0] w_count;
  logic                w_head;
  logic                w_run;
  logic                w_empty;
  logic                w_full;
  logic                w_deq;
  logic                w_mis;
  logic                w_enq;
  logic                w_underflow;
  logic [31:0]         w_correct_pc;

  brq_fifo #(
    .DEPTH (DEPTH)
  ) u_brq_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_enq),
    .i_push_data (pred_taken),
    .i_pop       (w_deq),
    .i_flush     (w_mis),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  // Queue handshake and resolution decode for the current cycle.
  always_comb begin
    w_run        = (r_state == S_RUN);
    w_empty      = (w_count == '0);
    w_full       = (w_count == CNT_BITS'(DEPTH));
    pred_ready   = !w_full && w_run;
    w_deq        = ex_valid && !w_empty && w_run;
    w_mis        = w_deq && (w_head != ex_taken);
    w_enq        = pred_valid && pred_ready && !w_mis;
    w_underflow  = ex_valid && w_empty && w_run;
    w_correct_pc = ex_taken ? ex_target : ex_pc_plus4;
  end

  // Recovery FSM next state: a mispredict costs exactly one bubble cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:     if (w_mis) w_state_next = S_RECOVER;
      S_RECOVER: w_state_next = S_RUN;
      default:   w_state_next = S_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Registered resolution strobes and redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brp_ex      <= '0;
      update      <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      brp_ex.mp_valid     <= w_deq;
      brp_ex.mispredicted <= w_mis;
      update              <= w_deq;
      redirect            <= w_mis;
      if (w_mis) begin
        redirect_pc <= w_correct_pc;
      end
    end
  end

  // Saturating statistics counters and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mp_count      <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (w_deq && (br_count != '1)) begin
        br_count <= br_count + CNT_W'(1);
      end
      if (w_mis && (mp_count != '1)) begin
        mp_count <= mp_count + CNT_W'(1);
      end
      if (w_underflow) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_br_resolver.sv
// Scoreboard bench for br_resolver: a queue-based reference model predicts
// each cycle's registered outputs, which are compared one edge later.
module tb_br_resolver;
  import rv32i_types::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_valid, pred_taken, ex_valid, ex_taken;
  logic [31:0] ex_target, ex_pc_plus4;

  logic        pred_ready, update, redirect, underflow_err;
  brp_ex_t     brp_ex;
  logic [31:0] redirect_pc, br_count, mp_count;

  logic        pred_ready4, update4, redirect4, underflow_err4;
  brp_ex_t     brp_ex4;
  logic [31:0] redirect_pc4;
  logic [3:0]  br_count4, mp_count4;

  always #5 clk = ~clk;

  br_resolver #(.DEPTH(DEPTH), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pc_plus4(ex_pc_plus4), .brp_ex(brp_ex), .update(update),
    .redirect(redirect), .redirect_pc(redirect_pc), .br_count(br_count),
    .mp_count(mp_count), .underflow_err(underflow_err)
  );

  br_resolver #(.DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready4),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pc_plus4(ex_pc_plus4), .brp_ex(brp_ex4), .update(update4),
    .redirect(redirect4), .redirect_pc(redirect_pc4), .br_count(br_count4),
    .mp_count(mp_count4), .underflow_err(underflow_err4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit          mpv, mis, upd, red, uf;
    logic [31:0] rpc, br, mp;
    logic [3:0]  br4, mp4;
  } exp_t;

  exp_t        sb[$];
  bit          mq[$];
  bit          m_rec;
  bit          m_uf;
  logic [31:0] m_br, m_mp, m_rpc;
  logic [3:0]  m4_br, m4_mp;

  function automatic void model_reset();
    mq.delete();
    sb.delete();
    m_rec = 1'b0;
    m_uf  = 1'b0;
    m_br  = '0;
    m_mp  = '0;
    m_rpc = '0;
    m4_br = '0;
    m4_mp = '0;
  endfunction

  // One clock cycle: drive at negedge, predict, compare after posedge.
  task automatic cyc(input bit pv, input bit pt, input bit ev, input bit et,
                     input logic [31:0] tgt, input logic [31:0] pc4);
    exp_t e;
    bit run, rdy, deq, mis, enq;
    pred_valid  = pv;
    pred_taken  = pt;
    ex_valid    = ev;
    ex_taken    = et;
    ex_target   = tgt;
    ex_pc_plus4 = pc4;
    #1;
    run = !m_rec;
    rdy = (mq.size() != DEPTH) && run;
    check("pred_ready", pred_ready, rdy);
    deq = ev && (mq.size() != 0) && run;
    mis = deq && (mq[0] != et);
    enq = pv && rdy && !mis;
    if (deq && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
    if (mis && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
    if (deq && m4_br != 4'hF) m4_br = m4_br + 4'd1;
    if (mis && m4_mp != 4'hF) m4_mp = m4_mp + 4'd1;
    if (mis) m_rpc = et ? tgt : pc4;
    if (ev && mq.size() == 0 && run) m_uf = 1'b1;
    e.mpv = deq; e.mis = mis; e.upd = deq; e.red = mis; e.uf = m_uf;
    e.rpc = m_rpc; e.br = m_br; e.mp = m_mp; e.br4 = m4_br; e.mp4 = m4_mp;
    sb.push_back(e);
    if (mis) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(pt);
    end
    m_rec = run && mis;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("mp_valid",     brp_ex.mp_valid,     e.mpv);
      check("mispredicted", brp_ex.mispredicted, e.mis);
      check("update",       update,              e.upd);
      check("redirect",     redirect,            e.red);
      check("redirect_pc",  redirect_pc,         e.rpc);
      check("br_count",     br_count,            e.br);
      check("mp_count",     mp_count,            e.mp);
      check("underflow",    underflow_err,       e.uf);
      check("br_count4",    br_count4,           e.br4);
      check("mp_count4",    mp_count4,           e.mp4);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse asserted away from any posedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_mp_valid",  brp_ex.mp_valid,     1'b0);
    check("rst_mispred",   brp_ex.mispredicted, 1'b0);
    check("rst_update",    update,              1'b0);
    check("rst_redirect",  redirect,            1'b0);
    check("rst_rpc",       redirect_pc,         32'h0);
    check("rst_br_count",  br_count,            32'h0);
    check("rst_mp_count",  mp_count,            32'h0);
    check("rst_underflow", underflow_err,       1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] br_snap, mp_snap;

  initial begin
    rst_n = 1'b1;
    pred_valid = 1'b0; pred_taken = 1'b0; ex_valid = 1'b0; ex_taken = 1'b0;
    ex_target = '0; ex_pc_plus4 = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Correct predictions T,N,T
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h100, 32'h10);
    cyc(0, 0, 1, 0, 32'h200, 32'h20);
    cyc(0, 0, 1, 1, 32'h300, 32'h30);
    check("tnt_br_count", br_count, 32'd3);
    check("tnt_mp_count", mp_count, 32'd0);

    // Mispredict N vs taken -> redirect to target, one recovery bubble
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h0000_0400, 32'h0000_0104);
    check("mis_redirect_pc", redirect_pc, 32'h400);
    check("mis_mp_count", mp_count, 32'd1);
    cyc(1, 1, 1, 1, 32'h999, 32'h888);
    cyc(0, 0, 0, 0, 0, 0);
    check("hold_redirect_pc", redirect_pc, 32'h400);

    // Fill to full, then dequeue with pred_valid held while full
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 32'h500, 32'h50);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);

    // Underflow on empty queue is sticky and leaves counters alone
    br_snap = br_count;
    mp_snap = mp_count;
    cyc(0, 0, 1, 1, 32'h600, 32'h60);
    check("uf_flag", underflow_err, 1'b1);
    check("uf_update", update, 1'b0);
    check("uf_br_count", br_count, br_snap);
    check("uf_mp_count", mp_count, mp_snap);
    cyc(0, 0, 0, 0, 0, 0);
    check("uf_sticky", underflow_err, 1'b1);

    // Mispredict with same-cycle enqueue, then reset during recovery
    do_reset();
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 32'h700, 32'h2000);
    check("rec_redirect", redirect, 1'b1);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    check("dropped_entry_uf", underflow_err, 1'b1);

    // Saturation of 4-bit counters after 17 mispredicts
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 32'h1000 + 32'(i), 32'h4);
      cyc(0, 0, 0, 0, 0, 0);
    end
    check("sat_br_count4", br_count4, 4'hF);
    check("sat_mp_count4", mp_count4, 4'hF);
    check("sat_br_count", br_count, 32'd17);
    check("sat_mp_count", mp_count, 32'd17);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
